gray_pseudocolor: RTL and testbench
===================================

# gray_pseudocolor

Parametrised gray-to-pseudocolour mapper for the camera video path. It takes a GW-bit grayscale pixel stream with sync/valid sideband and outputs RGB at configurable widths. Four colormaps are available and are switched only at frame boundaries. The block sits between the gray conversion stage and the display/VGA formatter, and delays the sideband by the same pipeline latency as the pixel data.

## Interface
Parameters:
- GW, 8: gray input width; legal range 4..12.
- RW, 5: red output width; must satisfy RW ≤ GW.
- GOW, 6: green output width; must satisfy GOW ≤ GW.
- BW, 5: blue output width; must satisfy BW ≤ GW.
- DEFAULT_MODE, 1: colormap selected after reset.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- mode_i, input, 2: requested colormap. 0 = gray, 1 = jet, 2 = hot, 3 = inverted gray.
- in_valid, input, 1: in_gray is a valid pixel this cycle.
- in_vsync, input, 1: frame sync, active-high.
- in_hsync, input, 1: line sync, active-high.
- in_gray, input, GW: grayscale pixel.
- out_valid, output, 1: output pixel is valid.
- out_vsync, output, 1: in_vsync delayed by 2 cycles.
- out_hsync, output, 1: in_hsync delayed by 2 cycles.
- out_r, output, RW: red.
- out_g, output, GOW: green.
- out_b, output, BW: blue.
- mode_active, output, 2: colormap currently in use.

## Operation
Definitions:
- M = 2^GW − 1.
- k = in_gray[GW-1:GW-2] (segment index).
- o = in_gray[GW-3:0] (offset within segment).
- up = {o, o[GW-3:GW-4]}. This spans 0..M exactly across each segment.
- dn = M − up.

Frame-synchronous mode control:
- A vsync rising edge is a cycle where in_vsync = 1 and the registered in_vsync from the previous cycle = 0.
- On such a cycle, mode_active loads mode_i. The pixel sampled in that same cycle uses the new mode.
- mode_i changes at any other time have no effect until the next vsync rising edge.

Stage 1 computes full-width components R, G, B (each GW bits):
- Mode 0: R = G = B = in_gray.
- Mode 3: R = G = B = M − in_gray.
- Mode 1 (jet):
  - k=0: R=0, G=M, B=dn.
  - k=1: R=0, G=dn, B=up.
  - k=2: R=up, G=0, B=M.
  - k=3: R=M, G=0, B=dn.
  - Every input code is covered; there is no gap at any segment boundary.
- Mode 2 (hot):
  - k=0: R=up, G=0, B=0.
  - k=1: R=M, G=up, B=0.
  - k=2: R=M, G=M, B=up.
  - k=3: R=M, G=M, B=M.

Stage 2 reduces each component to its output width by keeping the MSBs, with no rounding:
- out_r = R[GW-1 -: RW].
- out_g = G[GW-1 -: GOW].
- out_b = B[GW-1 -: BW].

No arithmetic may overflow. All intermediate values are GW bits and unsigned.

## Timing
- Latency: 2 cycles from in_* to out_*. This applies equally to valid, vsync, hsync and colour.
- Throughput: one pixel per cycle. There is no backpressure.
- Sync handling: vsync and hsync propagate every cycle regardless of in_valid.
- Colour hold: colour registers load only when the corresponding stage valid bit is 1. When out_valid = 0, out_r, out_g and out_b hold their last valid values.
- Reset values:
  - out_valid, out_vsync, out_hsync, out_r, out_g, out_b = 0.
  - The internal registered in_vsync = 0.
  - mode_active = DEFAULT_MODE.
- Reset asserted mid-frame: the pipeline empties immediately, and no stale pixel emerges after release.
- vsync already high when reset releases: this counts as a rising edge on the first cycle after release, because the registered value is 0.
- vsync rising edge on an invalid cycle: the mode still updates.
- Simultaneous vsync rising edge and a mode_i change: the new mode_i value is captured.

## Test plan
All scenarios use GW=8, RW=5, GOW=6, BW=5.
- Jet boundaries (mode 1 latched by a vsync pulse), gray inputs 0, 63, 64, 127, 128, 191, 192, 255 → RGB (0,63,31), (0,63,0), (0,63,0), (0,0,31), (0,0,31), (31,0,31), (31,0,31), (31,0,0), each exactly 2 cycles after its input.
- Hot mode, gray 100 → (31,36,0). Gray 0 → (0,0,0). Gray 255 → (31,63,31).
- Mode gating: set mode_i from 1 to 2 mid-frame with no vsync edge → output stays jet. Pulse vsync → the first pixel in the vsync-edge cycle is hot, and mode_active = 2.
- Mode 0 and mode 3, gray 0xA5 → (20,41,20) and (11,22,11) respectively.
- Sideband alignment: random valid gaps and hsync/vsync patterns → out_valid/out_hsync/out_vsync equal the inputs delayed by 2 cycles. Colour holds during invalid cycles.
- Assert rst for 1 cycle while the pipeline is full → all outputs 0 on the next cycle, mode_active = 1, and no valid output until 2 cycles after new valid input.

Source files
------------

// File: rtl/gray_pseudocolor.sv
// Gray-to-pseudocolour mapper: stage 1 forms full-width RGB from the selected colormap,
// stage 2 keeps the MSBs for each output width. Sideband rides the same two-stage pipe.
module gray_pseudocolor #(
    parameter int         GW           = 8,
    parameter int         RW           = 5,
    parameter int         GOW          = 6,
    parameter int         BW           = 5,
    parameter logic [1:0] DEFAULT_MODE = 2'd1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     mode_i,
    input  logic           in_valid,
    input  logic           in_vsync,
    input  logic           in_hsync,
    input  logic [GW-1:0]  in_gray,
    output logic           out_valid,
    output logic           out_vsync,
    output logic           out_hsync,
    output logic [RW-1:0]  out_r,
    output logic [GOW-1:0] out_g,
    output logic [BW-1:0]  out_b,
    output logic [1:0]     mode_active
);

    localparam logic [GW-1:0] MAX  = {GW{1'b1}};
    localparam logic [GW-1:0] ZERO = {GW{1'b0}};

    localparam logic [1:0] MODE_GRAY = 2'd0;
    localparam logic [1:0] MODE_JET  = 2'd1;
    localparam logic [1:0] MODE_HOT  = 2'd2;
    localparam logic [1:0] MODE_INV  = 2'd3;

    logic            vsync_prev_r;
    logic            vsync_rise_s;
    logic [1:0]      mode_active_r;
    logic [1:0]      mode_eff_s;
    logic [3*GW-1:0] rgb_s;

    logic            s1_valid_r;
    logic            s1_vsync_r;
    logic            s1_hsync_r;
    logic [GW-1:0]   s1_r_r;
    logic [GW-1:0]   s1_g_r;
    logic [GW-1:0]   s1_b_r;
    logic            unused_lsb_s;

    // up ramps 0..MAX across each quarter of the input range; dn is its mirror.
    function automatic logic [3*GW-1:0] colormap(input logic [1:0] mode, input logic [GW-1:0] gray);
        logic [1:0]    k;
        logic [GW-3:0] o;
        logic [GW-1:0] up;
        logic [GW-1:0] dn;
        logic [GW-1:0] r;
        logic [GW-1:0] g;
        logic [GW-1:0] b;
        k  = gray[GW-1 -: 2];
        o  = gray[GW-3:0];
        up = {o, o[GW-3 -: 2]};
        dn = MAX - up;
        case (mode)
            MODE_GRAY: begin r = gray;       g = gray;       b = gray;       end
            MODE_INV:  begin r = MAX - gray; g = MAX - gray; b = MAX - gray; end
            MODE_JET: begin
                case (k)
                    2'd0:    begin r = ZERO; g = MAX;  b = dn;   end
                    2'd1:    begin r = ZERO; g = dn;   b = up;   end
                    2'd2:    begin r = up;   g = ZERO; b = MAX;  end
                    2'd3:    begin r = MAX;  g = ZERO; b = dn;   end
                    default: begin r = ZERO; g = ZERO; b = ZERO; end
                endcase
            end
            MODE_HOT: begin
                case (k)
                    2'd0:    begin r = up;   g = ZERO; b = ZERO; end
                    2'd1:    begin r = MAX;  g = up;   b = ZERO; end
                    2'd2:    begin r = MAX;  g = MAX;  b = up;   end
                    2'd3:    begin r = MAX;  g = MAX;  b = MAX;  end
                    default: begin r = ZERO; g = ZERO; b = ZERO; end
                endcase
            end
            default: begin r = ZERO; g = ZERO; b = ZERO; end
        endcase
        return {r, g, b};
    endfunction

    // Mode for the current pixel: a vsync rising edge takes mode_i immediately.
    always_comb begin
        vsync_rise_s = in_vsync & ~vsync_prev_r;
        if (vsync_rise_s) begin
            mode_eff_s = mode_i;
        end else begin
            mode_eff_s = mode_active_r;
        end
        rgb_s = colormap(mode_eff_s, in_gray);
    end

    // Frame-synchronous mode register and vsync edge history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_prev_r  <= 1'b0;
            mode_active_r <= DEFAULT_MODE;
        end else begin
            vsync_prev_r <= in_vsync;
            if (vsync_rise_s) begin
                mode_active_r <= mode_i;
            end
        end
    end

    // Stage 1: sideband every cycle, colour only on valid pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_vsync_r <= 1'b0;
            s1_hsync_r <= 1'b0;
            s1_r_r     <= ZERO;
            s1_g_r     <= ZERO;
            s1_b_r     <= ZERO;
        end else begin
            s1_valid_r <= in_valid;
            s1_vsync_r <= in_vsync;
            s1_hsync_r <= in_hsync;
            if (in_valid) begin
                s1_r_r <= rgb_s[3*GW-1 -: GW];
                s1_g_r <= rgb_s[2*GW-1 -: GW];
                s1_b_r <= rgb_s[GW-1:0];
            end
        end
    end

    // Stage 2: truncate to output widths; colour holds across invalid cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_r     <= {RW{1'b0}};
            out_g     <= {GOW{1'b0}};
            out_b     <= {BW{1'b0}};
        end else begin
            out_valid <= s1_valid_r;
            out_vsync <= s1_vsync_r;
            out_hsync <= s1_hsync_r;
            if (s1_valid_r) begin
                out_r <= s1_r_r[GW-1 -: RW];
                out_g <= s1_g_r[GW-1 -: GOW];
                out_b <= s1_b_r[GW-1 -: BW];
            end
        end
    end

    // Truncated LSBs are intentionally dropped.
    assign unused_lsb_s = ^{s1_r_r, s1_g_r, s1_b_r};
    assign mode_active  = mode_active_r;

endmodule

// File: tb/tb_gray_pseudocolor.sv
// Scoreboard bench for gray_pseudocolor (GW=8, RW=5, GOW=6, BW=5): expected outputs are queued
// as stimulus is driven and popped two cycles later, when the DUT presents them.
module tb_gray_pseudocolor;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode_i;
    logic       in_valid;
    logic       in_vsync;
    logic       in_hsync;
    logic [7:0] in_gray;
    logic       out_valid;
    logic       out_vsync;
    logic       out_hsync;
    logic [4:0] out_r;
    logic [5:0] out_g;
    logic [4:0] out_b;
    logic [1:0] mode_active;

    always #5 clk = ~clk;

    gray_pseudocolor #(
        .GW(8), .RW(5), .GOW(6), .BW(5), .DEFAULT_MODE(2'd1)
    ) dut (
        .clk(clk), .rst(rst), .mode_i(mode_i),
        .in_valid(in_valid), .in_vsync(in_vsync), .in_hsync(in_hsync), .in_gray(in_gray),
        .out_valid(out_valid), .out_vsync(out_vsync), .out_hsync(out_hsync),
        .out_r(out_r), .out_g(out_g), .out_b(out_b), .mode_active(mode_active)
    );

    typedef struct {
        logic       v;
        logic       vs;
        logic       hs;
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } exp_t;

    typedef struct packed {
        logic        v;
        logic        vs;
        logic        hs;
        logic [7:0]  g;
        logic [1:0]  m;
        logic [15:0] x;
    } stim_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] tb_mode;
    logic       tb_vs_prev;
    logic [4:0] last_r;
    logic [5:0] last_g;
    logic [4:0] last_b;

    function automatic logic [15:0] c3(input int r, input int g, input int b);
        return {r[4:0], g[5:0], b[4:0]};
    endfunction

    function automatic stim_t mk(input logic v, input logic vs, input logic hs,
                                 input logic [7:0] g, input logic [1:0] m, input logic [15:0] x);
        stim_t s;
        s.v = v; s.vs = vs; s.hs = hs; s.g = g; s.m = m; s.x = x;
        return s;
    endfunction

    // Reference colormap written from the arithmetic definition, then truncated to 5/6/5.
    function automatic logic [15:0] model(input logic [1:0] m, input logic [7:0] gy);
        int k, o, up, dn, r, g, b;
        k  = gy / 64;
        o  = gy % 64;
        up = o * 4 + o / 16;
        dn = 255 - up;
        r = 0; g = 0; b = 0;
        case (m)
            2'd0: begin r = gy; g = gy; b = gy; end
            2'd3: begin r = 255 - gy; g = 255 - gy; b = 255 - gy; end
            2'd1: begin
                if (k == 0)      begin r = 0;   g = 255; b = dn;  end
                else if (k == 1) begin r = 0;   g = dn;  b = up;  end
                else if (k == 2) begin r = up;  g = 0;   b = 255; end
                else             begin r = 255; g = 0;   b = dn;  end
            end
            default: begin
                if (k == 0)      begin r = up;  g = 0;   b = 0;   end
                else if (k == 1) begin r = 255; g = up;  b = 0;   end
                else if (k == 2) begin r = 255; g = 255; b = up;  end
                else             begin r = 255; g = 255; b = 255; end
            end
        endcase
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

    function automatic string fmt(input logic [20:0] p);
        return $sformatf("v=%0b vs=%0b hs=%0b rgb=(%0d,%0d,%0d) mode=%0d",
                         p[20], p[19], p[18], p[17:13], p[12:7], p[6:2], p[1:0]);
    endfunction

    function automatic logic [20:0] pack_exp(input exp_t e, input logic [1:0] m);
        return {e.v, e.vs, e.hs, e.r, e.g, e.b, m};
    endfunction

    // Drive one cycle of input and queue what the DUT must show two cycles later.
    task automatic drive(input logic v, input logic vs, input logic hs, input logic [7:0] gy,
                         input logic [1:0] m, input bit use_model, input logic [15:0] x);
        exp_t        e;
        logic [15:0] c;
        in_valid = v; in_vsync = vs; in_hsync = hs; in_gray = gy; mode_i = m;
        if (vs && !tb_vs_prev) tb_mode = m;
        tb_vs_prev = vs;
        if (v) begin
            c      = use_model ? model(tb_mode, gy) : x;
            last_r = c[15:11];
            last_g = c[10:5];
            last_b = c[4:0];
        end
        e.v = v; e.vs = vs; e.hs = hs; e.r = last_r; e.g = last_g; e.b = last_b;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        sb.delete();
        tb_mode    = 2'd1;
        tb_vs_prev = 1'b0;
        last_r     = 5'd0;
        last_g     = 6'd0;
        last_b     = 5'd0;
    endtask

    task automatic seed_after_reset();
        exp_t e;
        e.v = 1'b0; e.vs = 1'b0; e.hs = 1'b0; e.r = 5'd0; e.g = 6'd0; e.b = 5'd0;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        rst = 1'b1;
        in_valid = 1'b0; in_vsync = 1'b0; in_hsync = 1'b0; in_gray = 8'd0; mode_i = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        got = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
        total++;
        if (got !== {19'd0, 2'd1}) begin
            bad++;
            $display("FAIL reset got %s exp %s", fmt(got), fmt({19'd0, 2'd1}));
        end
        rst = 1'b0;
        seed_after_reset();
    endtask

    task automatic test_jet();
        stim_t       st[$];
        exp_t        e;
        logic [20:0] got, want;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0,   2'd1, 16'd0));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 8'd0,   2'd1, c3(0, 63, 31)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd63,  2'd1, c3(0, 63, 0)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd64,  2'd1, c3(0, 63, 0)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd127, 2'd1, c3(0, 0, 31)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd128, 2'd1, c3(0, 0, 31)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd191, 2'd1, c3(31, 0, 31)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd192, 2'd1, c3(31, 0, 31)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd255, 2'd1, c3(31, 0, 0)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd0));
        foreach (st[i]) begin
            drive(st[i].v, st[i].vs, st[i].hs, st[i].g, st[i].m, 1'b0, st[i].x);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL jet[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_hot();
        stim_t       st[$];
        exp_t        e;
        logic [20:0] got, want;
        st.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0,   2'd2, 16'd0));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd100, 2'd2, c3(31, 36, 0)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd0,   2'd2, c3(0, 0, 0)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd255, 2'd2, c3(31, 63, 31)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0,   2'd2, 16'd0));
        foreach (st[i]) begin
            drive(st[i].v, st[i].vs, st[i].hs, st[i].g, st[i].m, 1'b0, st[i].x);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hot[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_mode_gating();
        stim_t       st[$];
        exp_t        e;
        logic [20:0] got, want;
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'd100, 2'd1, c3(0, 27, 18)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd100, 2'd2, c3(0, 27, 18)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'd100, 2'd2, c3(0, 27, 18)));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'd100, 2'd2, c3(31, 36, 0)));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'd0,   2'd1, c3(0, 0, 0)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'd0,   2'd1, 16'd0));
        foreach (st[i]) begin
            drive(st[i].v, st[i].vs, st[i].hs, st[i].g, st[i].m, 1'b0, st[i].x);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gating[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
        total++;
        if (mode_active !== 2'd2) begin
            bad++;
            $display("FAIL gating_mode got %0d exp 2", mode_active);
        end
    endtask

    task automatic test_gray_modes();
        stim_t       st[$];
        exp_t        e;
        logic [20:0] got, want;
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'hA5, 2'd0, c3(20, 41, 20)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'hA5, 2'd3, c3(20, 41, 20)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 16'd0));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'hA5, 2'd3, c3(11, 22, 11)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 2'd3, c3(31, 63, 31)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 2'd3, 16'd0));
        foreach (st[i]) begin
            drive(st[i].v, st[i].vs, st[i].hs, st[i].g, st[i].m, 1'b0, st[i].x);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL gray_modes[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_sideband();
        exp_t        e;
        logic [20:0] got, want;
        logic        v, vs, hs;
        logic [7:0]  gy;
        logic [1:0]  m;
        for (int i = 0; i < 120; i++) begin
            v  = ($urandom_range(0, 2) != 0);
            vs = ($urandom_range(0, 5) == 0) || (tb_vs_prev && $urandom_range(0, 1) == 1);
            hs = ($urandom_range(0, 3) == 0);
            gy = 8'($urandom_range(0, 255));
            m  = 2'($urandom_range(0, 3));
            drive(v, vs, hs, gy, m, 1'b1, 16'd0);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL sideband[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_reset_midframe();
        stim_t       st[$];
        exp_t        e;
        logic [20:0] got, want;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 8'(40 + i * 70), 2'd0, 1'b1, 16'd0);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL fill[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
        rst = 1'b1;
        in_valid = 1'b0; in_vsync = 1'b1; in_hsync = 1'b0; in_gray = 8'd0; mode_i = 2'd3;
        model_reset();
        #1;
        got = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
        total++;
        if (got !== {19'd0, 2'd1}) begin
            bad++;
            $display("FAIL rst_async got %s exp %s", fmt(got), fmt({19'd0, 2'd1}));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seed_after_reset();
        // vsync is already high at release, so the first cycle is a rising edge.
        st.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0,   2'd3, 16'd0));
        st.push_back(mk(1'b0, 1'b1, 1'b0, 8'd0,   2'd0, 16'd0));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 8'hA5,  2'd0, c3(11, 22, 11)));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00,  2'd0, c3(31, 63, 31)));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00,  2'd0, 16'd0));
        st.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00,  2'd0, 16'd0));
        foreach (st[i]) begin
            drive(st[i].v, st[i].vs, st[i].hs, st[i].g, st[i].m, 1'b0, st[i].x);
            @(posedge clk); #1;
            e    = sb.pop_front();
            want = pack_exp(e, tb_mode);
            got  = {out_valid, out_vsync, out_hsync, out_r, out_g, out_b, mode_active};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL post_rst[%0d] got %s exp %s", i, fmt(got), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset();
        test_jet();
        test_hot();
        test_mode_gating();
        test_gray_modes();
        test_sideband();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
